// File: rtl/c3po_pkg.sv
// Shared constants and types for the c3po receive-side reassembler.
// Beat and packet geometry, plus the assembly state encoding.
package c3po_pkg;

    localparam int BEAT_BYTES    = 32;
    localparam int PKT_BYTES     = 160;
    localparam int BEAT_W        = BEAT_BYTES * 8;
    localparam int PKT_W         = PKT_BYTES * 8;
    localparam int MAX_BEATS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASSM = 2'd1,
        DROP = 2'd2,
        DONE = 2'd3
    } state_t;

    // A beat must carry between 1 and BEAT_BYTES bytes.
    function automatic logic vbc_ok(input logic [7:0] vbc);
        return (vbc != 8'd0) && (vbc <= 8'(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/c3po_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module c3po_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/c3po_reassembler.sv
// Rebuilds one c3po input-format packet from a stream of 32-byte output beats
// and presents it as a single-cycle sop=eop transfer under valid/ready.
module c3po_reassembler
    import c3po_pkg::*;
#(
    parameter int CNT_SIZE_P  = 8,
    parameter int MAX_BEATS_P = MAX_BEATS_DEF
) (
    input  logic                          sig_clock,
    input  logic                          sig_reset_L,
    input  logic                          sig_i_sop,
    input  logic                          sig_i_eop,
    input  logic                          sig_i_val,
    input  logic [7:0]                    sig_i_vbc,
    input  logic [BEAT_W-1:0]             sig_i_data,
    input  logic [3:0]                    sig_cfg_port_id,
    output logic                          sig_ready,
    output logic                          sig_o_val,
    input  logic                          sig_o_rdy,
    output logic                          sig_o_sop,
    output logic                          sig_o_eop,
    output logic [7:0]                    sig_o_vbc,
    output logic [3:0]                    sig_o_id,
    output logic [MAX_BEATS_P*BEAT_W-1:0] sig_o_data,
    output logic [CNT_SIZE_P-1:0]         sig_pkt_cnt,
    output logic [CNT_SIZE_P-1:0]         sig_err_cnt
);

    localparam int IDX_W     = $clog2(MAX_BEATS_P + 1);
    localparam int PKT_LIMIT = MAX_BEATS_P * BEAT_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BEATS_P - 1);

    state_t                          state_reg, state_next;
    logic [IDX_W-1:0]                idx_reg, idx_next;
    logic [7:0]                      acc_vbc_reg, acc_vbc_next;
    logic [3:0]                      id_reg, id_next;
    logic                            done_err_reg, done_err_next;
    logic [BEAT_W-1:0]               buf_reg [MAX_BEATS_P];
    logic [MAX_BEATS_P*BEAT_W-1:0]   buf_flat;

    logic                            o_val_reg;
    logic [7:0]                      o_vbc_reg;
    logic [3:0]                      o_id_reg;
    logic [MAX_BEATS_P*BEAT_W-1:0]   o_data_reg;

    logic [BEAT_W-1:0]               beat_masked;
    logic [8:0]                      vbc_sum;
    logic                            sum_over;
    logic                            out_free;
    logic                            o_fire;
    logic                            start;
    logic                            wr_en;
    logic [IDX_W-1:0]                wr_idx;
    logic                            clr;
    logic                            err_inc;
    logic                            load_out;

    // Bytes past the beat's vbc are zeroed so the rebuilt packet carries no stale data.
    for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_mask
        assign beat_masked[gi*8 +: 8] = (8'(gi) < sig_i_vbc) ? sig_i_data[gi*8 +: 8] : 8'h00;
    end

    for (genvar gi = 0; gi < MAX_BEATS_P; gi++) begin : g_flat
        assign buf_flat[gi*BEAT_W +: BEAT_W] = buf_reg[gi];
    end

    assign vbc_sum  = {1'b0, acc_vbc_reg} + {1'b0, sig_i_vbc};
    assign sum_over = (vbc_sum > 9'(PKT_LIMIT));
    assign o_fire   = o_val_reg && sig_o_rdy;
    assign out_free = !o_val_reg || sig_o_rdy;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        acc_vbc_next  = acc_vbc_reg;
        id_next       = id_reg;
        done_err_next = (state_reg == DONE) ? done_err_reg : 1'b0;
        wr_en         = 1'b0;
        wr_idx        = idx_reg;
        clr           = 1'b0;
        err_inc       = 1'b0;
        load_out      = 1'b0;
        start         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sig_i_val) begin
                    if (sig_i_sop) start   = 1'b1;
                    else           err_inc = 1'b1;
                end
            end
            ASSM: begin
                if (sig_i_val) begin
                    if (sig_i_sop) begin
                        start   = 1'b1;
                        err_inc = 1'b1;
                    end else if (!vbc_ok(sig_i_vbc) || sum_over) begin
                        err_inc    = 1'b1;
                        state_next = sig_i_eop ? IDLE : DROP;
                    end else begin
                        wr_en        = 1'b1;
                        acc_vbc_next = vbc_sum[7:0];
                        idx_next     = idx_reg + IDX_W'(1);
                        if (sig_i_eop) begin
                            state_next = DONE;
                        end else if (idx_reg == LAST_IDX) begin
                            err_inc    = 1'b1;
                            state_next = DROP;
                        end
                    end
                end
            end
            DROP: begin
                // The dropped packet was already counted when it entered DROP.
                if (sig_i_val) begin
                    if (sig_i_sop)      start      = 1'b1;
                    else if (sig_i_eop) state_next = IDLE;
                end
            end
            DONE: begin
                if (out_free) begin
                    load_out   = 1'b1;
                    state_next = IDLE;
                end
                if (sig_i_val) begin
                    if (sig_i_sop) begin
                        start = 1'b1;
                        if (!out_free) err_inc = 1'b1;
                    end else if (!done_err_reg) begin
                        err_inc       = 1'b1;
                        done_err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A new packet restarts assembly from beat 0 regardless of the current state.
        if (start) begin
            done_err_next = 1'b0;
            if (vbc_ok(sig_i_vbc)) begin
                clr          = 1'b1;
                wr_en        = 1'b1;
                wr_idx       = '0;
                id_next      = sig_cfg_port_id;
                acc_vbc_next = sig_i_vbc;
                idx_next     = IDX_W'(1);
                state_next   = sig_i_eop ? DONE : ASSM;
            end else begin
                err_inc    = 1'b1;
                state_next = sig_i_eop ? IDLE : DROP;
            end
        end
    end

    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            acc_vbc_reg  <= '0;
            id_reg       <= '0;
            done_err_reg <= 1'b0;
            for (int i = 0; i < MAX_BEATS_P; i++) buf_reg[i] <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            acc_vbc_reg  <= acc_vbc_next;
            id_reg       <= id_next;
            done_err_reg <= done_err_next;
            for (int i = 0; i < MAX_BEATS_P; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) buf_reg[i] <= beat_masked;
                else if (clr)                       buf_reg[i] <= '0;
            end
        end
    end

    // Output register reads the old buffer, so a restart in the same cycle is safe.
    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) begin
            o_val_reg  <= 1'b0;
            o_vbc_reg  <= '0;
            o_id_reg   <= '0;
            o_data_reg <= '0;
        end else if (load_out) begin
            o_val_reg  <= 1'b1;
            o_vbc_reg  <= acc_vbc_reg;
            o_id_reg   <= id_reg;
            o_data_reg <= buf_flat;
        end else if (o_fire) begin
            o_val_reg  <= 1'b0;
        end
    end

    c3po_sat_cnt #(.W(CNT_SIZE_P)) u_pkt_cnt (
        .clk   (sig_clock),
        .rst_n (sig_reset_L),
        .inc   (o_fire),
        .cnt   (sig_pkt_cnt)
    );

    c3po_sat_cnt #(.W(CNT_SIZE_P)) u_err_cnt (
        .clk   (sig_clock),
        .rst_n (sig_reset_L),
        .inc   (err_inc),
        .cnt   (sig_err_cnt)
    );

    assign sig_ready  = (state_reg == IDLE);
    assign sig_o_val  = o_val_reg;
    assign sig_o_sop  = o_val_reg;
    assign sig_o_eop  = o_val_reg;
    assign sig_o_vbc  = o_vbc_reg;
    assign sig_o_id   = o_id_reg;
    assign sig_o_data = o_data_reg;

endmodule

// File: tb/tb_c3po_reassembler.sv
// Bench for c3po_reassembler: table of packets plus hand-written corner sequences,
// delivered packets checked against a scoreboard queue.
module tb_c3po_reassembler;

    localparam int PW = 1280;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_sop = 1'b0, i_eop = 1'b0, i_val = 1'b0;
    logic [7:0]     i_vbc = '0;
    logic [255:0]   i_data = '0;
    logic [3:0]     cfg_id = '0;
    logic           ready, o_val, o_rdy = 1'b1, o_sop, o_eop;
    logic [7:0]     o_vbc;
    logic [3:0]     o_id;
    logic [PW-1:0]  o_data;
    logic [7:0]     pkt_cnt, err_cnt;

    c3po_reassembler #(.CNT_SIZE_P(8), .MAX_BEATS_P(5)) dut (
        .sig_clock       (clk),
        .sig_reset_L     (rst_n),
        .sig_i_sop       (i_sop),
        .sig_i_eop       (i_eop),
        .sig_i_val       (i_val),
        .sig_i_vbc       (i_vbc),
        .sig_i_data      (i_data),
        .sig_cfg_port_id (cfg_id),
        .sig_ready       (ready),
        .sig_o_val       (o_val),
        .sig_o_rdy       (o_rdy),
        .sig_o_sop       (o_sop),
        .sig_o_eop       (o_eop),
        .sig_o_vbc       (o_vbc),
        .sig_o_id        (o_id),
        .sig_o_data      (o_data),
        .sig_pkt_cnt     (pkt_cnt),
        .sig_err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    vbc;
        logic [3:0]    id;
        logic [PW-1:0] data;
    } exp_t;

    typedef struct {
        int              nb;
        logic [4:0][7:0] vbcs;
        logic [3:0]      id;
        int              seed;
        logic [7:0]      exp_vbc;
        bit              exp_good;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   exp_pkt = 0;
    int   exp_err = 0;
    vec_t vecs[7];

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic vec_t mk(input int nb, input int v0, input int v1, input int v2, input int v3,
                                input int v4, input int id, input int seed, input int ev, input bit good);
        vec_t v;
        v.nb = nb;
        v.vbcs[0] = 8'(v0); v.vbcs[1] = 8'(v1); v.vbcs[2] = 8'(v2);
        v.vbcs[3] = 8'(v3); v.vbcs[4] = 8'(v4);
        v.id = 4'(id); v.seed = seed; v.exp_vbc = 8'(ev); v.exp_good = good;
        return v;
    endfunction

    function automatic logic [255:0] beat_data(input int k, input int seed);
        logic [255:0] d;
        for (int j = 0; j < 32; j++) d[j*8 +: 8] = 8'((32*k + j + seed) & 255);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_data(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        int bad;
        bad = -1;
        for (int b = PW/8 - 1; b >= 0; b--) if (act[b*8 +: 8] !== req[b*8 +: 8]) bad = b;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s byte %0d actual=%02h required=%02h", name, bad, act[bad*8 +: 8], req[bad*8 +: 8]);
        end
    endtask

    // Scoreboard side: every accepted output packet must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_val && o_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pkt actual vbc=%0d id=%0d required none", o_vbc, o_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pkt_vbc", 64'(o_vbc), 64'(mon_e.vbc));
                chk("pkt_id", 64'(o_id), 64'(mon_e.id));
                chk("pkt_sop_eop", 64'({o_sop, o_eop}), 64'(2'b11));
                chk_data("pkt_data", o_data, mon_e.data);
                exp_pkt = sat8(exp_pkt + 1);
                $display("pkt delivered id=%0d vbc=%0d", o_id, o_vbc);
            end
        end
    end

    task automatic send_beat(input logic sop, input logic eop, input logic [7:0] vbc, input logic [255:0] d);
        i_val = 1'b1; i_sop = sop; i_eop = eop; i_vbc = vbc; i_data = d;
        @(posedge clk); #1;
        i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        exp_t         e;
        logic [255:0] d;
        e.data = '0;
        cfg_id = v.id;
        for (int k = 0; k < v.nb; k++) begin
            d = beat_data(k, v.seed);
            for (int j = 0; j < 32 && j < int'(v.vbcs[k]); j++) e.data[(32*k + j)*8 +: 8] = d[j*8 +: 8];
            send_beat(k == 0, k == v.nb - 1, v.vbcs[k], d);
        end
        e.vbc = v.exp_vbc;
        e.id  = v.id;
        if (v.exp_good) exp_q.push_back(e);
        else            exp_err = sat8(exp_err + 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_val) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s_drain actual pending=%0d required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 64'(ready), 64'(1));
    endtask

    task automatic check_counters(input string name);
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
        chk({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_ready"}, 64'(ready), 64'(1));
        chk({name, "_o_val"}, 64'(o_val), 64'(0));
        chk({name, "_o_vbc"}, 64'(o_vbc), 64'(0));
        chk({name, "_o_id"}, 64'(o_id), 64'(0));
        chk_data({name, "_o_data"}, o_data, '0);
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(0));
        chk({name, "_err_cnt"}, 64'(err_cnt), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = mk(5, 32, 32, 32, 32, 32,  3,   0, 160, 1'b1);
        vecs[1] = mk(1,  7,  0,  0,  0,  0,  5,  17,   7, 1'b1);
        vecs[2] = mk(3, 32, 10,  1,  0,  0,  9,  50,  43, 1'b1);
        vecs[3] = mk(2, 32,  0,  0,  0,  0,  1,  60,   0, 1'b0);
        vecs[4] = mk(2, 40,  5,  0,  0,  0,  2,  70,   0, 1'b0);
        vecs[5] = mk(4,  1,  2,  3,  4,  0, 15, 200,  10, 1'b1);
        vecs[6] = mk(2, 32, 32,  0,  0,  0,  0,  99,  64, 1'b1);

        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            send_pkt(vecs[t]);
            repeat (3) @(negedge clk);
            drain($sformatf("vec%0d", t));
            check_counters($sformatf("vec%0d", t));
        end

        // eop beat sampled at edge N: DONE during N+1, o_val during N+2.
        v = mk(1, 7, 0, 0, 0, 0, 6, 123, 7, 1'b1);
        send_pkt(v);
        @(negedge clk);
        chk("lat_n1_o_val", 64'(o_val), 64'(0));
        chk("lat_n1_ready", 64'(ready), 64'(0));
        @(negedge clk);
        chk("lat_n2_o_val", 64'(o_val), 64'(1));
        drain("lat");
        check_counters("lat");

        // Backpressure: second packet parks in DONE until the first is drained.
        o_rdy = 1'b0;
        v = mk(2, 32, 20, 0, 0, 0, 4, 11, 52, 1'b1);
        send_pkt(v);
        wait_ready("bp1");
        v = mk(2, 16, 32, 0, 0, 0, 8, 77, 48, 1'b1);
        send_pkt(v);
        repeat (3) @(negedge clk);
        chk("bp_park_ready", 64'(ready), 64'(0));
        chk("bp_park_o_val", 64'(o_val), 64'(1));
        chk("bp_park_o_vbc", 64'(o_vbc), 64'(52));
        o_rdy = 1'b1;
        drain("bp");
        check_counters("bp");

        // Six beats without eop: dropped once, next packet arrives normally.
        send_beat(1'b1, 1'b0, 8'd32, beat_data(0, 5));
        for (int k = 1; k < 6; k++) send_beat(1'b0, 1'b0, 8'd32, beat_data(k, 5));
        exp_err = sat8(exp_err + 1);
        @(negedge clk);
        chk("long_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("long_o_val", 64'(o_val), 64'(0));
        v = mk(2, 32, 3, 0, 0, 0, 12, 33, 35, 1'b1);
        send_pkt(v);
        drain("long_next");
        check_counters("long_next");

        // sop on the third beat restarts; the new packet must come through intact.
        send_beat(1'b1, 1'b0, 8'd32, beat_data(0, 9));
        send_beat(1'b0, 1'b0, 8'd32, beat_data(1, 9));
        exp_err = sat8(exp_err + 1);
        v = mk(2, 32, 32, 0, 0, 0, 10, 140, 64, 1'b1);
        send_pkt(v);
        drain("restart");
        check_counters("restart");
        send_beat(1'b0, 1'b0, 8'd5, beat_data(0, 1));
        exp_err = sat8(exp_err + 1);
        @(negedge clk);
        check_counters("stray");

        // Asynchronous reset in the middle of beat 2.
        send_beat(1'b1, 1'b0, 8'd32, beat_data(0, 3));
        i_val = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_vbc = 8'd32; i_data = beat_data(1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        i_val = 1'b0;
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = mk(3, 32, 32, 9, 0, 0, 7, 45, 73, 1'b1);
        send_pkt(v);
        drain("post_reset");
        check_counters("post_reset");

        // Error counter saturation via a long run of stray beats.
        i_val = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_vbc = 8'd4;
        repeat (260) @(posedge clk);
        #1;
        i_val = 1'b0;
        exp_err = sat8(exp_err + 260);
        @(negedge clk);
        chk("sat_err_cnt", 64'(err_cnt), 64'(exp_err));
        for (int k = 0; k < 3; k++) send_beat(1'b0, 1'b0, 8'd4, beat_data(0, 2));
        exp_err = sat8(exp_err + 3);
        @(negedge clk);
        chk("sat_hold_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("sat_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c3po_reassembler.md
Name: c3po_reassembler

Overview:
- Receive-side counterpart of the c3po output stream. Collects 32-byte output beats (sop/val/eop framed, per-beat vbc) and rebuilds one 160-byte packet in the c3po input-packet format.
- Presents the rebuilt packet as a single-cycle sop=eop=1 transfer with total vbc and id, under a valid/ready handshake.
- Used in loopback and checker paths next to c3po.

Parameters:
- CNT_SIZE_P, 8, width of packet and error counters (saturating)
- MAX_BEATS_P, 5, maximum beats per packet (5 x 32 = 160 bytes)

Ports:
- sig_clock  in  1  clock
- sig_reset_L  in  1  async reset, active low
- sig_i_sop  in  1  first beat of packet
- sig_i_eop  in  1  last beat of packet
- sig_i_val  in  1  beat valid
- sig_i_vbc  in  8  valid bytes in beat, 1..32
- sig_i_data  in  256  beat data; byte 0 in bits [7:0]
- sig_cfg_port_id  in  4  id stamped on output packet
- sig_ready  out  1  may start a new packet (sop) next cycle
- sig_o_val  out  1  rebuilt packet valid
- sig_o_rdy  in  1  consumer accepts packet
- sig_o_sop  out  1  equals sig_o_val
- sig_o_eop  out  1  equals sig_o_val
- sig_o_vbc  out  8  total bytes, 1..160
- sig_o_id  out  4  id captured at sop
- sig_o_data  out  1280  packet data; beat k lands at bytes 32k..32k+31
- sig_pkt_cnt  out  CNT_SIZE_P  packets delivered
- sig_err_cnt  out  CNT_SIZE_P  packets dropped

Behaviour:
- Reset (async, sig_reset_L=0): state IDLE; sig_ready=1; sig_o_val=0; sig_o_vbc/id/data=0; both counters 0; beat index 0.
- Clock/reset: one clock; reset is asynchronous and active-low (sig_clock, sig_reset_L).
- Beats count only when sig_i_val=1. The input side has no backpressure; sig_ready gates only sop.
- States:
  - IDLE: val&sop -> write beat 0, capture id, acc_vbc=vbc. If eop also set, go to DONE; else go to ASSM. A val beat without sop is dropped, err_cnt+1.
  - ASSM: val & !sop -> write beat[idx], acc_vbc+=vbc, idx+1. On eop go to DONE. If idx reaches MAX_BEATS_P without eop, go to DROP, err_cnt+1. val&sop restarts a new packet from beat 0 (old packet dropped, err_cnt+1).
  - DROP: discard beats until val&eop, then go to IDLE. val&sop restarts as in ASSM.
  - DONE: assembly buffer complete. If the output register is empty, or is being drained this cycle (o_val&o_rdy), move to the output register next cycle and go to IDLE; otherwise hold.
- sig_ready=1 only in IDLE. Upstream sop while not ready is a protocol violation and gets the same handling as sop in ASSM/DROP/DONE: restart, err_cnt+1. In DONE, incoming beats are dropped and counted once per packet.
- Latency: eop beat at cycle N -> sig_o_val=1 at N+2 when the output register is free.
- Output register: holds data until sig_o_val&sig_o_rdy; sig_pkt_cnt+1 on that cycle. Bytes beyond vbc are zero-filled: the buffer is cleared on sop.
- Arithmetic: acc_vbc is 8 bits. A sum >160 is an error: drop, err_cnt+1, go to IDLE/DROP per eop. A beat vbc of 0 or >32 is treated the same way.
- Counters saturate at all-ones and never wrap.
- Reset mid-packet discards all state; no partial output.

Decomposition:
- Package c3po_pkg: beat width 32 bytes, packet width 160 bytes, MAX_BEATS_P default, state enum (IDLE, ASSM, DROP, DONE).
- One sub-module, c3po_sat_cnt: saturating counter, instantiated twice.

Test Plan:
- 5 beats, vbc 32,32,32,32,32, data bytes 0..159 -> one o_val, vbc=160, data byte i = i, id=cfg id, pkt_cnt=1.
- Single beat sop=eop=1, vbc=7 -> o_val 2 cycles later, vbc=7, bytes 7..159 = 0.
- Hold o_rdy=0, send two 2-beat packets -> second parks in DONE with sig_ready=0. Raise o_rdy -> both delivered in order, pkt_cnt=2, err_cnt=0.
- 6 beats without eop -> err_cnt=1, no o_val. Next clean packet delivered normally.
- sop arriving on beat 3 of a packet -> err_cnt=1, second packet delivered intact. A beat with val and no sop in IDLE -> err_cnt+1.
- Assert reset during beat 2 -> all outputs at reset values. Following packet correct. Force err_cnt to 255 -> stays at 255.
